pipeline_ctrl: RTL

Central stall/flush controller for the five-stage CPU pipeline. It produces the per-stage stall vector that every inter-stage pipeline register consumes as its current-stage/next-stage stall pair. It also issues the flush pulse and redirect PC on exceptions, and sequences multi-cycle EX operations (mul/div) by holding EX stalled for a programmed number of cycles. It sits beside the datapath in the CPU top level, taking stall requests from IF/ID/EX/MEM and the exception request from MEM.

---
 rtl/pipeline_ctrl_pkg.sv | 31 +++
 rtl/pipeline_ctrl_mc_sequencer.sv | 79 +++++++
 rtl/pipeline_ctrl.sv | 80 ++++++++
 3 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared stall indices, stall levels, reset level and mc FSM encoding
package pipeline_ctrl_pkg;

  localparam int STALL_PC  = 0;
  localparam int STALL_IF  = 1;
  localparam int STALL_ID  = 2;
  localparam int STALL_EX  = 3;
  localparam int STALL_MEM = 4;
  localparam int STALL_WB  = 5;
  localparam int STALL_W   = STALL_WB + 1;

  localparam logic STOP       = 1'b1;
  localparam logic NO_STOP    = 1'b0;
  localparam logic RST_ENABLE = 1'b1;

  typedef enum logic [1:0] {
    MC_IDLE = 2'd0,
    MC_BUSY = 2'd1,
    MC_DONE = 2'd2
  } mc_state_e;

  // Stall vector for a request from stage k: stages 0..k hold, later stages drain.
  function automatic logic [STALL_W-1:0] stall_upto(input int k);
    logic [STALL_W-1:0] m;
    for (int i = 0; i < STALL_W; i++) begin
      m[i] = (i <= k) ? STOP : NO_STOP;
    end
    return m;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_mc_sequencer.sv
// rtl/pipeline_ctrl_mc_sequencer.sv - multi-cycle EX op sequencer (IDLE/BUSY/DONE + down-counter)
module pipeline_ctrl_mc_sequencer
  import pipeline_ctrl_pkg::*;
#(
  parameter int MC_LEN_W = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                hold,
  input  logic                start,
  input  logic [MC_LEN_W-1:0] len,
  output logic                ex_stall,
  output logic                done
);

  mc_state_e           state_q, state_d;
  logic [MC_LEN_W-1:0] cnt_q, cnt_d;
  logic [MC_LEN_W-1:0] len_eff;

  assign len_eff = (len == '0) ? MC_LEN_W'(1) : len;

  // The start cycle itself is the first stalled cycle, so BUSY lasts len_eff-1 cycles.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ex_stall = 1'b0;
    done     = 1'b0;
    case (state_q)
      MC_IDLE: begin
        if (start) begin
          ex_stall = 1'b1;
          if (len_eff == MC_LEN_W'(1)) begin
            state_d = MC_DONE;
            cnt_d   = '0;
          end else begin
            state_d = MC_BUSY;
            cnt_d   = len_eff - MC_LEN_W'(1);
          end
        end
      end
      MC_BUSY: begin
        ex_stall = 1'b1;
        if (cnt_q <= MC_LEN_W'(1)) begin
          state_d = MC_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - MC_LEN_W'(1);
        end
      end
      MC_DONE: begin
        done = 1'b1;
        if (!hold) begin
          state_d = MC_IDLE;
        end
      end
      default: begin
        state_d = MC_IDLE;
        cnt_d   = '0;
      end
    endcase
    if (flush) begin
      state_d = MC_IDLE;
      cnt_d   = '0;
      done    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q <= MC_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - pipeline stall/flush controller with multi-cycle EX sequencing
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int MC_LEN_W = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_stall_req,
  input  logic                id_stall_req,
  input  logic                ex_stall_req,
  input  logic                mem_stall_req,
  input  logic                ex_mc_start,
  input  logic [MC_LEN_W-1:0] ex_mc_len,
  input  logic                exc_req,
  input  logic [ADDR_W-1:0]   exc_vector,
  output logic [5:0]          stall,
  output logic                flush,
  output logic [ADDR_W-1:0]   new_pc,
  output logic                ex_mc_done,
  output logic [31:0]         stall_cycles
);

  logic        mc_ex_stall;
  logic        mem_hold;
  logic [31:0] stall_cycles_q, stall_cycles_d;

  // Derived straight from inputs (equals stall[STALL_MEM]) to keep the sequencer off the stall path.
  assign mem_hold = mem_stall_req && !exc_req;

  pipeline_ctrl_mc_sequencer #(
    .MC_LEN_W(MC_LEN_W)
  ) u_mc_sequencer (
    .clk      (clk),
    .rst      (rst),
    .flush    (exc_req),
    .hold     (mem_hold),
    .start    (ex_mc_start),
    .len      (ex_mc_len),
    .ex_stall (mc_ex_stall),
    .done     (ex_mc_done)
  );

  always_comb begin
    stall  = {STALL_W{NO_STOP}};
    flush  = 1'b0;
    new_pc = '0;
    if (exc_req) begin
      flush  = 1'b1;
      new_pc = exc_vector;
    end else if (mem_stall_req) begin
      stall = stall_upto(STALL_MEM);
    end else if (ex_stall_req || mc_ex_stall) begin
      stall = stall_upto(STALL_EX);
    end else if (id_stall_req) begin
      stall = stall_upto(STALL_ID);
    end else if (if_stall_req) begin
      stall = stall_upto(STALL_IF);
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if ((stall[STALL_PC] == STOP) && !flush) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      stall_cycles_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;

endmodule
